// File: rtl/host_byte_bridge.sv
// host_byte_bridge: turns a framed byte protocol (OP, ADDR, LEN, payload)
// into MMIO register writes and reads. Read data and acknowledges are
// returned on the TX byte stream. Bursts auto-increment the address, which
// wraps modulo 2^ADDR_W.
module host_byte_bridge #(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] host_addr,
  output logic [7:0]        host_wr_data,
  output logic              host_wr_en,
  input  logic [7:0]        host_rd_data,
  output logic              busy,
  output logic              err_pulse
);

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] BYTE_ACK = 8'h4B;
  localparam logic [7:0] BYTE_ERR = 8'h45;

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE,
    GET_ADDR,
    GET_LEN,
    WR_DATA,
    WR_COMMIT,
    RD_SAMPLE,
    RD_SEND,
    SEND_ACK,
    SEND_ERR
  } state_e;

  state_e state_q, state_d;

  logic              rx_ready_q, rx_ready_d;
  logic              op_wr_q, op_wr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [7:0]        remain_q, remain_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic [ADDR_W-1:0] host_addr_q, host_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic              err_q, err_d;

  logic rx_wait;
  logic rx_fire;
  logic tx_fire;
  logic op_ok;
  logic timed_out;

  // rx_ready_q is the registered decode of the current state, so it also
  // stays low for the first cycle after reset release.
  assign rx_wait   = (state_q == GET_ADDR) || (state_q == GET_LEN) || (state_q == WR_DATA);
  assign rx_fire   = rx_valid && rx_ready_q;
  assign tx_fire   = tx_valid_q && tx_ready;
  assign op_ok     = (rx_data == OP_WRITE) || (rx_data == OP_READ);
  assign timed_out = rx_wait && !rx_fire && (cnt_q == CNT_LAST);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic for the frame parser.
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (rx_fire) state_d = op_ok ? GET_ADDR : SEND_ERR;
      end
      GET_ADDR: begin
        if (rx_fire)        state_d = GET_LEN;
        else if (timed_out) state_d = IDLE;
      end
      GET_LEN: begin
        if (rx_fire) begin
          if (rx_data == 8'h00) state_d = SEND_ACK;
          else if (op_wr_q)     state_d = WR_DATA;
          else                  state_d = RD_SAMPLE;
        end else if (timed_out) begin
          state_d = IDLE;
        end
      end
      WR_DATA: begin
        if (rx_fire)        state_d = WR_COMMIT;
        else if (timed_out) state_d = IDLE;
      end
      WR_COMMIT: state_d = (remain_q == 8'h00) ? SEND_ACK : WR_DATA;
      RD_SAMPLE: state_d = RD_SEND;
      RD_SEND: begin
        if (tx_fire) state_d = (remain_q == 8'h00) ? SEND_ACK : RD_SAMPLE;
      end
      SEND_ACK, SEND_ERR: begin
        if (tx_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values: MMIO strobe, address walk, TX byte,
  // remaining count, timeout counter and error pulse.
  always_comb begin
    rx_ready_d  = (state_d == IDLE) || (state_d == GET_ADDR) ||
                  (state_d == GET_LEN) || (state_d == WR_DATA);
    op_wr_d     = op_wr_q;
    base_d      = base_q;
    remain_d    = remain_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    host_addr_d = host_addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    err_d       = 1'b0;
    // Counts consecutive cycles spent waiting for RX; any accepted byte,
    // any state change or any non-waiting state clears it.
    cnt_d       = (rx_wait && !rx_fire && !timed_out) ? cnt_q + CNT_W'(1) : '0;

    unique case (state_q)
      IDLE: begin
        if (rx_fire) begin
          op_wr_d = (rx_data == OP_WRITE);
          if (!op_ok) begin
            err_d      = 1'b1;
            tx_valid_d = 1'b1;
            tx_data_d  = BYTE_ERR;
          end
        end
      end
      GET_ADDR: begin
        if (rx_fire)        base_d = rx_data[ADDR_W-1:0];
        else if (timed_out) err_d  = 1'b1;
      end
      GET_LEN: begin
        if (rx_fire) begin
          host_addr_d = base_q;
          remain_d    = rx_data;
          if (rx_data == 8'h00) begin
            tx_valid_d = 1'b1;
            tx_data_d  = BYTE_ACK;
          end
        end else if (timed_out) begin
          err_d = 1'b1;
        end
      end
      WR_DATA: begin
        if (rx_fire) begin
          wr_data_d = rx_data;
          wr_en_d   = 1'b1;
          remain_d  = (remain_q != 8'h00) ? remain_q - 8'd1 : 8'h00;
        end else if (timed_out) begin
          err_d = 1'b1;
        end
      end
      WR_COMMIT: begin
        host_addr_d = host_addr_q + ADDR_W'(1);
        if (remain_q == 8'h00) begin
          tx_valid_d = 1'b1;
          tx_data_d  = BYTE_ACK;
        end
      end
      RD_SAMPLE: begin
        tx_valid_d = 1'b1;
        tx_data_d  = host_rd_data;
        remain_d   = (remain_q != 8'h00) ? remain_q - 8'd1 : 8'h00;
      end
      RD_SEND: begin
        if (tx_fire) begin
          host_addr_d = host_addr_q + ADDR_W'(1);
          if (remain_q == 8'h00) begin
            // ACK follows the last read byte without a bubble.
            tx_valid_d = 1'b1;
            tx_data_d  = BYTE_ACK;
          end else begin
            tx_valid_d = 1'b0;
          end
        end
      end
      SEND_ACK, SEND_ERR: begin
        if (tx_fire) tx_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ready_q  <= 1'b0;
      op_wr_q     <= 1'b0;
      base_q      <= '0;
      remain_q    <= 8'h00;
      cnt_q       <= '0;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      host_addr_q <= '0;
      wr_data_q   <= 8'h00;
      wr_en_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rx_ready_q  <= rx_ready_d;
      op_wr_q     <= op_wr_d;
      base_q      <= base_d;
      remain_q    <= remain_d;
      cnt_q       <= cnt_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      host_addr_q <= host_addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      err_q       <= err_d;
    end
  end

  assign rx_ready     = rx_ready_q;
  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;
  assign host_addr    = host_addr_q;
  assign host_wr_data = wr_data_q;
  assign host_wr_en   = wr_en_q;
  assign busy         = (state_q != IDLE);
  assign err_pulse    = err_q;

endmodule

// File: doc/host_byte_bridge.md
# host_byte_bridge

Byte-stream host bridge between the UART transceiver and the NPU's MMIO register file. Parses a framed command protocol from the RX byte stream into single-cycle MMIO register writes and combinational register reads, and returns read data and acknowledges on the TX byte stream. Supports auto-incrementing bursts, so the host can load a full 8-byte MMVR word, which rings the doorbell, in one frame.

## Interface
- ADDR_W, 8: MMIO address width. Legal range 1..8.
- TIMEOUT_CYCLES, 1000000: maximum wait for the next RX byte inside a frame before the frame is aborted. Must be ≥ 2.
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  bridge accepts rx_data this cycle
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts tx_data this cycle
- host_addr  out  ADDR_W  MMIO register address (registered)
- host_wr_data  out  8  MMIO write data (registered)
- host_wr_en  out  1  MMIO write strobe, one cycle per byte
- host_rd_data  in  8  MMIO read data, combinational from host_addr
- busy  out  1  high whenever state ≠ IDLE
- err_pulse  out  1  one-cycle pulse on a bad opcode or timeout

## Operation
- Frame format: OP, ADDR, LEN, then payload. Payload is LEN bytes for a write and none for a read. LEN is 0..255.
- OP 0x57 (write): data byte i is written to ADDR+i, with the address wrapping mod 2^ADDR_W. After the last write the bridge sends ACK 0x4B.
- OP 0x52 (read): the bridge returns LEN bytes read from ADDR+i (same wrap), then sends ACK 0x4B.
- LEN=0: no MMIO access. The bridge sends ACK only.
- Any other OP: the bridge pulses err_pulse, sends 0x45, and returns to IDLE. No ADDR or LEN bytes are consumed.
- States:
  - IDLE: accept OP.
  - GET_ADDR: accept ADDR.
  - GET_LEN: accept LEN.
  - WR_DATA: accept a payload byte.
  - WR_COMMIT: drive host_wr_en.
  - RD_SAMPLE: capture host_rd_data.
  - RD_SEND: hold read byte on TX.
  - SEND_ACK: hold 0x4B on TX.
  - SEND_ERR: hold 0x45 on TX.
- Transitions:
  - GET_LEN goes to WR_DATA for a write or RD_SAMPLE for a read. With LEN=0 it goes to SEND_ACK.
  - WR_DATA goes to WR_COMMIT. WR_COMMIT goes back to WR_DATA, or to SEND_ACK after the last byte.
  - RD_SAMPLE goes to RD_SEND. RD_SEND goes back to RD_SAMPLE, or to SEND_ACK after the last byte.
  - SEND_ACK and SEND_ERR go to IDLE once the TX handshake completes.
- host_addr is loaded with ADDR in GET_LEN. It increments by 1, wrapping, after each WR_COMMIT and after each completed RD_SEND handshake.
- A remaining-count register is loaded with LEN and decrements per byte. It is 8 bits wide, with no underflow.
- Timeout: a counter clears on every accepted RX byte and on entry to a state that waits for RX. It counts only while the bridge waits in GET_ADDR, GET_LEN or WR_DATA.
  - On reaching TIMEOUT_CYCLES the bridge pulses err_pulse, goes to IDLE, and sends nothing.
  - Writes already committed in that frame stay committed.
- The counter does not run in TX states. TX backpressure never times out.

## Timing
- Reset values:
  - state IDLE
  - rx_ready 0
  - tx_valid 0, tx_data 0x00
  - host_addr 0, host_wr_data 0, host_wr_en 0
  - busy 0, err_pulse 0
- rx_ready is high only in IDLE, GET_ADDR, GET_LEN and WR_DATA. A byte is accepted on a cycle where rx_valid and rx_ready are both high.
- rx_ready is low in all other states, including WR_COMMIT. Back-to-back payload bytes are therefore accepted at most every 2 cycles.
- Write: payload byte accepted in cycle N. In cycle N+1 host_wr_en=1 with host_wr_data equal to the byte and host_addr equal to the target address. host_wr_en is 0 otherwise.
- Read: host_rd_data is sampled in RD_SAMPLE, when host_addr has been stable for at least 1 cycle. tx_valid rises in the next cycle.
- TX: tx_valid and tx_data are registered and held constant until tx_valid and tx_ready are both high. Transfer completes on that cycle, and tx_valid is 0 in the following cycle unless another byte follows immediately.
- Latency for a single write, from OP accepted to ACK tx_valid (no stalls): OP, ADDR, LEN, DATA, COMMIT, then ACK valid. ACK valid is at OP+5 cycles if all RX bytes arrive back-to-back.
- err_pulse is exactly 1 cycle. For a bad opcode it is in the cycle after OP is accepted; for a timeout it is in the abort cycle.
- Async reset mid-frame: immediate return to reset values. No partial write strobe is emitted.

## Test plan
- Single write: RX 0x57, 0x05, 0x01, 0xA5 -> one host_wr_en pulse at addr 0x05 with data 0xA5; TX 0x4B.
- Burst write with wrap (ADDR_W=8): RX 0x57, 0xFE, 0x03, 0x11, 0x22, 0x33 -> writes 0xFE=0x11, 0xFF=0x22, 0x00=0x33; three strobes each exactly 1 cycle; TX 0x4B.
- Read with backpressure: model returns rd_data = addr ^ 0x5A; RX 0x52, 0x10, 0x02; hold tx_ready low 7 cycles per byte -> TX 0x4A, 0x4B, 0x4B; tx_data stable while stalled; no strobes.
- Zero length and bad opcode: RX 0x52, 0x00, 0x00 -> TX 0x4B only. RX 0x99 -> err_pulse 1 cycle, TX 0x45, next byte 0x57 parsed as OP.
- Timeout (TIMEOUT_CYCLES=16): RX 0x57, 0x20, 0x02, 0xAA, then silence -> one strobe at 0x20; err_pulse at 16 idle cycles; busy 0; no TX; next frame parses normally.
- Reset mid-burst: assert rst_n low between payload bytes -> all outputs at reset values the same cycle; after release RX 0x52, 0x00, 0x00 -> TX 0x4B.
